// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output block and the SPI register block.
package pwm_pkg;

  localparam int PWM_WIDTH  = 8;
  localparam int PWM_PERIOD = 256;

  typedef logic [PWM_WIDTH-1:0] pwm_cnt_t;

  // Duty value that means "on for the whole period" rather than 255/256.
  localparam pwm_cnt_t DUTY_FULL = 8'hFF;
  // Last counter value of a period; the step after it wraps to 0.
  localparam pwm_cnt_t CNT_LAST  = 8'hFF;

  // Register map of the SPI configuration block feeding this peripheral.
  typedef logic [7:0] reg_addr_t;
  localparam reg_addr_t ADDR_EN_OUT_UO  = 8'h00;
  localparam reg_addr_t ADDR_EN_OUT_UIO = 8'h01;
  localparam reg_addr_t ADDR_EN_PWM_UO  = 8'h02;
  localparam reg_addr_t ADDR_EN_PWM_UIO = 8'h03;
  localparam reg_addr_t ADDR_PWM_DUTY   = 8'h04;

  // Per-bit output select: disabled -> 0, enabled static -> 1, enabled PWM -> sig.
  function automatic logic [7:0] out_mux(input logic [7:0] en_out,
                                         input logic [7:0] en_pwm,
                                         input logic       sig);
    return en_out & (~en_pwm | {8{sig}});
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled 8-bit PWM counter. Produces the running count and a wrap strobe
// that is high on the single cycle whose step takes the count from 255 to 0.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13  // system clocks per counter step, must be >= 1
) (
  input  logic     clk,
  input  logic     rst,
  output pwm_cnt_t cnt,
  output logic     wrap
);

  // A PRESCALE of 1 still needs a one-bit prescaler so the compare stays legal.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] prescaler;
  logic            tick;

  assign tick = (prescaler == PS_LAST);
  assign wrap = tick && (cnt == CNT_LAST);

  // Prescaler: counts 0..PRESCALE-1 and restarts; tick marks its last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // PWM counter: one step per tick, natural modulo-256 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives the 16 chip output bits. Each bit is off, static high, or follows a
// shared PWM waveform whose duty is reloaded only at period boundaries.
// There is no handshake: every input is level-held configuration that is
// sampled on each rising clock edge and may change at any cycle.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_out_uo,
  input  logic [7:0] en_out_uio,
  input  logic [7:0] en_pwm_uo,
  input  logic [7:0] en_pwm_uio,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       period_start
);

  pwm_cnt_t pwm_cnt;
  pwm_cnt_t duty_active;
  logic     wrap;
  logic     pwm_sig;

  pwm_timebase #(
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk  (clk),
    .rst  (rst),
    .cnt  (pwm_cnt),
    .wrap (wrap)
  );

  // Duty shadow: take the requested duty only on the wrap step, so a period
  // always runs with one consistent duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_active <= '0;
    end else if (wrap) begin
      duty_active <= pwm_duty_cycle;
    end
  end

  // Compare: full-scale duty is held high across the wrap to avoid a 1-step dip.
  always_comb begin
    pwm_sig = 1'b0;
    if (duty_active == DUTY_FULL) begin
      pwm_sig = 1'b1;
    end else begin
      pwm_sig = (pwm_cnt < duty_active);
    end
  end

  // Registered output mux and period marker; both lag the counter by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      uo_out       <= '0;
      uio_out      <= '0;
      period_start <= 1'b0;
    end else begin
      uo_out       <= out_mux(en_out_uo, en_pwm_uo, pwm_sig);
      uio_out      <= out_mux(en_out_uio, en_pwm_uio, pwm_sig);
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral. Two instances share all inputs:
// dut2 runs with PRESCALE=2, dut1 with PRESCALE=1.
module tb_pwm_peripheral;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] en_out_uo, en_out_uio, en_pwm_uo, en_pwm_uio, duty;
  logic [7:0] uo2, uio2, uo1, uio1;
  logic       ps2, ps1;

  pwm_peripheral #(.PRESCALE(2)) dut2 (
    .clk            (clk),
    .rst            (rst),
    .en_out_uo      (en_out_uo),
    .en_out_uio     (en_out_uio),
    .en_pwm_uo      (en_pwm_uo),
    .en_pwm_uio     (en_pwm_uio),
    .pwm_duty_cycle (duty),
    .uo_out         (uo2),
    .uio_out        (uio2),
    .period_start   (ps2)
  );

  pwm_peripheral #(.PRESCALE(1)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .en_out_uo      (en_out_uo),
    .en_out_uio     (en_out_uio),
    .en_pwm_uo      (en_pwm_uo),
    .en_pwm_uio     (en_pwm_uio),
    .pwm_duty_cycle (duty),
    .uo_out         (uo1),
    .uio_out        (uio1),
    .period_start   (ps1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cfg(input logic [7:0] eo_uo, input logic [7:0] ep_uo,
                         input logic [7:0] eo_uio, input logic [7:0] ep_uio,
                         input logic [7:0] d);
    en_out_uo  = eo_uo;
    en_pwm_uo  = ep_uo;
    en_out_uio = eo_uio;
    en_pwm_uio = ep_uio;
    duty       = d;
  endtask

  // Advance at least one cycle, then stop on the next dut1 period_start.
  task automatic wait_ps1(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ps1 !== 1'b1 && n < 600);
    check(tag, 32'(ps1), 1);
  endtask

  // Watch dut1.uo_out[0] for n cycles; indices are 1-based cycles from call.
  task automatic observe(input int n, output int high, output int rise1,
                         output int rise2, output int fall1, output int falls,
                         output int ps_at);
    logic prev;
    high = 0; rise1 = 0; rise2 = 0; fall1 = 0; falls = 0; ps_at = 0;
    prev = uo1[0];
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      if (uo1[0]) high++;
      if (!prev && uo1[0]) begin
        if (rise1 == 0) rise1 = j;
        else if (rise2 == 0) rise2 = j;
      end
      if (prev && !uo1[0]) begin
        falls++;
        if (fall1 == 0) fall1 = j;
      end
      if (ps1 && ps_at == 0) ps_at = j;
      prev = uo1[0];
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int high, r1, r2, f1, nf, psa, h1, first2, first1, bad, pulses;

    rst = 1'b1;
    set_cfg(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Reset held three cycles with all inputs high.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_uo2", uo2, 0);
      check("rst_uio2", uio2, 0);
      check("rst_ps2", 32'(ps2), 0);
      check("rst_uo1", uo1, 0);
    end

    // Release; the current cycle is the first post-reset cycle (index 0).
    rst = 1'b0;
    first2 = 0;
    first1 = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (ps2 && first2 == 0) first2 = c;
      if (ps1 && first1 == 0) first1 = c;
    end
    check("first_ps_presc2", first2, 512);
    check("first_ps_presc1", first1, 256);

    // Static drive, PWM disabled.
    set_cfg(8'hA5, 8'h00, 8'h0F, 8'h00, 8'h00);
    @(negedge clk);
    check("static_uo2", uo2, 8'hA5);
    check("static_uio2", uio2, 8'h0F);
    check("static_uo1", uo1, 8'hA5);
    bad = 0;
    pulses = 0;
    for (int c = 0; c < 1536; c++) begin
      @(negedge clk);
      if (uo2 !== 8'hA5 || uio2 !== 8'h0F || uo1 !== 8'hA5 || uio1 !== 8'h0F) bad++;
      if (ps2) pulses++;
    end
    check("static_hold_bad", bad, 0);
    check("static_ps2_pulses", pulses, 3);

    // 50% duty at PRESCALE=1.
    set_cfg(8'h01, 8'h01, 8'h00, 8'h00, 8'd128);
    wait_ps1("d128_sync");
    observe(512, high, r1, r2, f1, nf, psa);
    check("d128_rise1", r1, 1);
    check("d128_high_run", f1 - r1, 128);
    check("d128_period", r2 - r1, 256);
    check("d128_high_total", high, 256);
    check("d128_ps_at", psa, 256);

    // Duty 0 over two periods.
    duty = 8'd0;
    wait_ps1("d0_sync");
    observe(512, high, r1, r2, f1, nf, psa);
    check("d0_high", high, 0);

    // Full-scale duty over two periods, no dip at the wrap.
    duty = 8'd255;
    wait_ps1("d255_sync");
    observe(512, high, r1, r2, f1, nf, psa);
    check("d255_high", high, 512);
    check("d255_falls", nf, 0);

    // Shadowing: duty changes mid-period at count 100.
    duty = 8'd64;
    wait_ps1("shadow_sync");
    observe(100, h1, r1, r2, f1, nf, psa);
    duty = 8'd192;
    observe(156, high, r1, r2, f1, nf, psa);
    check("shadow_cur_high", h1 + high, 64);
    check("shadow_ps_at", psa, 156);
    observe(256, high, r1, r2, f1, nf, psa);
    check("shadow_next_high", high, 192);

    // Reset mid-period while the output is high.
    duty = 8'd200;
    wait_ps1("midrst_sync");
    observe(150, high, r1, r2, f1, nf, psa);
    check("midrst_before", 32'(uo1[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_uo1", uo1, 0);
    check("midrst_ps1", 32'(ps1), 0);
    check("midrst_uo2", uo2, 0);
    rst = 1'b0;
    observe(256, high, r1, r2, f1, nf, psa);
    check("midrst_low_period", high, 0);
    check("midrst_ps_at", psa, 256);
    observe(256, high, r1, r2, f1, nf, psa);
    check("midrst_reload_high", high, 200);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
